fnd_scan_scheduler: RTL and testbench
=====================================

# fnd_scan_scheduler

Time-multiplexed scan scheduler for the 4-digit common-anode FND on the AXI4 FND controller IP. Accepts a binary value (0–9999) from the register-interface side over a ready/load handshake and converts it sequentially to BCD. It drives one digit at a time with a blanking interval between digits to suppress ghosting. New values take effect only at frame boundaries, so a digit never shows a mix of old and new values.

## Interface
- `CLK_DIV`, 50_000: i_clk cycles per digit slot (≥ BLANK_CYCLES+2).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all commons off.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  scan enable; low = display dark, scan held.
- `i_value`  in  14  binary value; >9999 clamps to 9999.
- `i_dp`  in  4  decimal-point request per digit, bit n = digit n.
- `i_load`  in  1  load strobe, accepted only when o_ready=1.
- `o_ready`  out  1  converter idle and no pending update.
- `o_fnd_com`  out  4  active-low digit commons, bit 0 = rightmost digit.
- `o_fnd_font`  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- `o_frame_tick`  out  1  one-cycle pulse at end of each digit-3 slot.

## Operation
- Reset values: o_fnd_com=4'b1111, o_fnd_font=8'hFF, o_ready=1, o_frame_tick=0; slot counter=0, digit index=0, display digits=0, dp=0, shadow invalid.
- Load path FSM: IDLE → CONV → PEND → IDLE.
  - IDLE, i_load=1: capture clamped i_value and i_dp → CONV.
  - CONV: double-dabble, one shift per cycle, 14 cycles → shadow BCD valid → PEND.
  - PEND: wait for frame end, or i_enable=0. Copy shadow to display registers → IDLE.
- i_load while o_ready=0: ignored, no queueing.
- Scan: slot counter 0..CLK_DIV-1; digit index advances 0→1→2→3→0 on wrap.
  - Counter < BLANK_CYCLES: com=4'b1111, font=8'hFF.
  - Otherwise: com has only bit[index] low; font = decode(digit[index]) with bit7 = ~dp[index].
- Decode: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (bit7 forced 1 before dp merge).
- Frame end: counter=CLK_DIV-1 and index=3. Pulse o_frame_tick; perform PEND transfer in the same cycle.
- i_enable=0: counter and index forced to 0, outputs dark (com=1111, font=FF). A PEND transfer happens immediately.
- Re-enable: scan restarts at digit 0 with a full blanking interval.
- Reset mid-conversion or mid-frame: all state returns to reset values; the pending value is discarded.

## Timing
- All outputs registered; com/font change one cycle after the counter reaches the boundary value.
- Load accepted at cycle T (i_load=1, o_ready=1): o_ready=0 from T+1, shadow valid at T+15.
- Transfer at the first frame end at or after T+15. o_ready=1 on the cycle after the transfer, and the new digits appear from the next digit-0 slot.
- Frame period = 4·CLK_DIV cycles; o_frame_tick high for exactly 1 cycle per frame.
- Simultaneous frame end and shadow-valid in the same cycle: the transfer occurs in that frame end.

## Configuration
- `FND_LZ_BLANK_EN` defined: leading-zero blanking. Digits above the most significant non-zero digit show font 8'hFF, except that their dp is still honored. Digit 0 always displays, so 0 shows as "   0".
- Undefined: all four digits always displayed, so 42 shows as "0042".

## Test plan
Use CLK_DIV=10, BLANK_CYCLES=2 for all cases.
- Reset, i_enable=1, no load → each slot shows 2 cycles com=1111, then 8 cycles font=C0. Com sequence 1110, 1101, 1011, 0111; o_frame_tick every 40 cycles.
- Load 1234 with i_dp=4'b0100 at T → o_ready=0 at T+1. Next frame shows digit0=99, digit1=B0, digit2=24 (A4 with dp), digit3=F9. o_ready returns after the transfer frame end.
- i_load pulsed again while o_ready=0 with 5678 → ignored; display keeps 1234.
- Load 12000 → clamps; display 9999 (90 ×4).
- Load 7 with FND_LZ_BLANK_EN → digits 3..1 FF, digit0 F8. Without the macro → C0, C0, C0, F8.
- Drop i_enable mid-slot during PEND → next cycle com=1111; transfer immediate. Re-enable: slot restarts at digit 0 with blanking. Assert i_reset mid-CONV → all outputs at reset values, o_ready=1.

Source files
------------

// File: rtl/fnd_scan_scheduler.sv
// Time-multiplexed 4-digit FND scan scheduler with a sequential binary-to-BCD load path.
// Optional build macro FND_LZ_BLANK_EN enables leading-zero blanking of the upper digits.
module fnd_scan_scheduler #(
    parameter int CLK_DIV      = 50_000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [13:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_load,
    output logic        o_ready,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font,
    output logic        o_frame_tick
);

    localparam int              CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [13:0]     VALUE_MAX = 14'd9999;
    localparam logic [3:0]      CONV_LAST = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [29:0]      conv_q, conv_d;
    logic [3:0]       step_q, step_d;
    logic [3:0]       dp_sh_q, dp_sh_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       disp_dp_q, disp_dp_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       com_q, com_d;
    logic [7:0]       font_q, font_d;
    logic             tick_q, tick_d;

    logic             frame_end_s;
    logic [13:0]      value_clamped_s;
    logic [3:0]       cur_digit_s;
    logic             lz_blank_s;
    logic [7:0]       glyph_s;

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}: correct nibbles, then shift.
    function automatic logic [29:0] dabble_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int n = 0; n < 4; n++) begin
            t[14+4*n +: 4] = (t[14+4*n +: 4] >= 4'd5) ? (t[14+4*n +: 4] + 4'd3)
                                                       : t[14+4*n +: 4];
        end
        return {t[28:0], 1'b0};
    endfunction

    // Active-low seven-segment pattern {dp,g,f,e,d,c,b,a} with dp off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign frame_end_s     = i_enable && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
    assign value_clamped_s = (i_value > VALUE_MAX) ? VALUE_MAX : i_value;

    // Load path: capture, convert, then hold in the shadow until a frame boundary or disable.
    always_comb begin
        state_d   = state_q;
        conv_d    = conv_q;
        step_d    = step_q;
        dp_sh_d   = dp_sh_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    conv_d  = {16'd0, value_clamped_s};
                    dp_sh_d = i_dp;
                    step_d  = 4'd0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                conv_d = dabble_step(conv_q);
                step_d = step_q + 4'd1;
                if (step_q == CONV_LAST) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_PEND: begin
                if (frame_end_s || !i_enable) begin
                    disp_d    = conv_q[29:14];
                    disp_dp_d = dp_sh_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Leading-zero detection: a digit blanks when it and every digit above it are zero.
    always_comb begin
        cur_digit_s = disp_q[{idx_q, 2'b00} +: 4];
`ifdef FND_LZ_BLANK_EN
        case (idx_q)
            2'd3:    lz_blank_s = (disp_q[15:12] == 4'd0);
            2'd2:    lz_blank_s = (disp_q[15:8] == 8'd0);
            2'd1:    lz_blank_s = (disp_q[15:4] == 12'd0);
            default: lz_blank_s = 1'b0;
        endcase
`else
        lz_blank_s = 1'b0;
`endif
        glyph_s = seg_decode(cur_digit_s);
    end

    // Scan sequencing and next output values; disable holds the scan at digit 0, dark.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        com_d  = 4'b1111;
        font_d = 8'hFF;
        tick_d = frame_end_s;
        if (!i_enable) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            idx_d = idx_q;
        end
        if (!i_enable || (cnt_q < CNT_BLANK)) begin
            com_d  = 4'b1111;
            font_d = 8'hFF;
        end else begin
            com_d  = ~(4'b0001 << idx_q);
            font_d = {~disp_dp_q[idx_q], (lz_blank_s ? 7'h7F : glyph_s[6:0])};
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            conv_q    <= 30'd0;
            step_q    <= 4'd0;
            dp_sh_q   <= 4'd0;
            disp_q    <= 16'd0;
            disp_dp_q <= 4'd0;
            ready_q   <= 1'b1;
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= 2'd0;
            com_q     <= 4'b1111;
            font_q    <= 8'hFF;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            conv_q    <= conv_d;
            step_q    <= step_d;
            dp_sh_q   <= dp_sh_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            com_q     <= com_d;
            font_q    <= font_d;
            tick_q    <= tick_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_fnd_com    = com_q;
    assign o_fnd_font   = font_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Scoreboard bench for fnd_scan_scheduler at CLK_DIV=10, BLANK_CYCLES=2; honours FND_LZ_BLANK_EN.
module tb_fnd_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [13:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        ready;
    logic [3:0]  com;
    logic [7:0]  font;
    logic        tick;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    fnd_scan_scheduler #(.CLK_DIV(10), .BLANK_CYCLES(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_enable     (enable),
        .i_value      (value),
        .i_dp         (dp),
        .i_load       (load),
        .o_ready      (ready),
        .o_fnd_com    (com),
        .o_fnd_font   (font),
        .o_frame_tick (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_ref(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected fonts of digits 3..0 packed as {d3,d2,d1,d0}.
    function automatic logic [31:0] model_frame(input int v, input logic [3:0] dpv);
        logic [31:0] r;
        int x;
        int div;
        logic [7:0] f;
        logic blank;
        r = 32'd0;
        x = (v > 9999) ? 9999 : v;
        div = 1;
        for (int n = 0; n < 4; n++) begin
`ifdef FND_LZ_BLANK_EN
            blank = (n > 0) && (x < div);
`else
            blank = 1'b0;
`endif
            f = blank ? 8'hFF : seg_ref((x / div) % 10);
            f[7] = ~dpv[n];
            r[8*n +: 8] = f;
            div = div * 10;
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (tick) begin
                found = 1'b1;
                break;
            end
        end
        check_val(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_ready(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (ready) begin
                found = 1'b1;
                break;
            end
        end
        check_val(tag, {31'd0, found}, 32'd1);
    endtask

    // Called on the cycle a frame starts (digit 0, counter 0); ends on the next frame start.
    task automatic capture_frame(input string tag);
        logic [31:0] exp;
        check_val({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() > 0)}, 32'd1);
        if (sb_q.size() == 0) return;
        exp = sb_q.pop_front();
        for (int off = 1; off <= 40; off++) begin
            step();
            if (off == 1) begin
                check_val({tag, "_blank_com"}, {28'd0, com}, 32'hF);
                check_val({tag, "_blank_font"}, {24'd0, font}, 32'hFF);
            end
            for (int d = 0; d < 4; d++) begin
                if (off == 3 + 10 * d) begin
                    check_val($sformatf("%s_d%0d_com", tag, d), {28'd0, com},
                              {28'd0, ~(4'b0001 << d)});
                    check_val($sformatf("%s_d%0d_font", tag, d), {24'd0, font},
                              {24'd0, exp[8*d +: 8]});
                end
            end
            if (off == 20) check_val({tag, "_tick_mid"}, {31'd0, tick}, 32'd0);
            if (off == 40) check_val({tag, "_tick_end"}, {31'd0, tick}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        value  = 14'd0;
        dp     = 4'd0;
        repeat (3) step();
        check_val("rst_com", {28'd0, com}, 32'hF);
        check_val("rst_font", {24'd0, font}, 32'hFF);
        check_val("rst_ready", {31'd0, ready}, 32'd1);
        check_val("rst_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;

        wait_tick(60, "boot_tick");
        sb_q.push_back(model_frame(0, 4'd0));
        capture_frame("idle0");

        value = 14'd1234; dp = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        check_val("busy_after_load", {31'd0, ready}, 32'd0);
        value = 14'd5678; dp = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        wait_ready(100, "ready_1234");
        check_val("xfer_on_tick", {31'd0, tick}, 32'd1);
        sb_q.push_back(model_frame(1234, 4'b0100));
        sb_q.push_back(model_frame(1234, 4'b0100));
        capture_frame("v1234");
        capture_frame("v1234_hold");

        // Load at c24: shadow valid exactly on the frame-end cycle.
        repeat (24) step();
        value = 14'd12000; dp = 4'd0; load = 1'b1;
        step();
        load = 1'b0;
        check_val("clamp_busy", {31'd0, ready}, 32'd0);
        repeat (15) step();
        check_val("edge_ready", {31'd0, ready}, 32'd1);
        check_val("edge_tick", {31'd0, tick}, 32'd1);
        sb_q.push_back(model_frame(12000, 4'd0));
        capture_frame("v9999");

        // Load at c25: shadow valid one cycle too late, transfer slips a frame.
        repeat (25) step();
        value = 14'd7; dp = 4'd0; load = 1'b1;
        step();
        load = 1'b0;
        check_val("late_busy", {31'd0, ready}, 32'd0);
        repeat (14) step();
        check_val("late_not_ready", {31'd0, ready}, 32'd0);
        check_val("late_tick1", {31'd0, tick}, 32'd1);
        repeat (40) step();
        check_val("late_ready", {31'd0, ready}, 32'd1);
        check_val("late_tick2", {31'd0, tick}, 32'd1);
        sb_q.push_back(model_frame(7, 4'd0));
        capture_frame("v7");

        step();
        value = 14'd4321; dp = 4'b1001; load = 1'b1;
        step();
        load = 1'b0;
        repeat (18) step();
        check_val("pend_wait", {31'd0, ready}, 32'd0);
        enable = 1'b0;
        step();
        check_val("dis_com", {28'd0, com}, 32'hF);
        check_val("dis_font", {24'd0, font}, 32'hFF);
        check_val("dis_xfer_ready", {31'd0, ready}, 32'd1);
        repeat (3) step();
        check_val("dis_hold_com", {28'd0, com}, 32'hF);
        check_val("dis_hold_tick", {31'd0, tick}, 32'd0);
        enable = 1'b1;
        sb_q.push_back(model_frame(4321, 4'b1001));
        capture_frame("reenable");

        value = 14'd5555; dp = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check_val("mid_rst_com", {28'd0, com}, 32'hF);
        check_val("mid_rst_font", {24'd0, font}, 32'hFF);
        check_val("mid_rst_ready", {31'd0, ready}, 32'd1);
        check_val("mid_rst_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;
        wait_tick(60, "post_rst_tick");
        sb_q.push_back(model_frame(0, 4'd0));
        sb_q.push_back(model_frame(0, 4'd0));
        capture_frame("post_rst_a");
        capture_frame("post_rst_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
